// File: rtl/gpmc_initiator.sv
// gpmc_initiator
// Synchronous multiplexed GPMC bus master. A single command from a valid/ready
// port is turned into one GPMC access: an address phase (ADDR_CYC periods),
// a data phase (DATA_CYC periods) and a turnaround with chip select released
// (TURN_CYC periods). A GPMC period is two clk cycles: gpmc_clk is 0 in the
// first and 1 in the second, so every bus output changes on the falling edge
// and is stable when the target samples on the rising edge.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write             1 = write, 0 = read
//   cmd_addr, cmd_wdata   word address and write data, captured on acceptance
//   rsp_valid             one-cycle completion pulse, first turnaround cycle
//   rsp_rdata             last read data, held until the next read
//   gpmc_ad_out/_oe/_in   multiplexed address/data bus and its tristate enable
//   gpmc_advn, gpmc_csn1, gpmc_wein, gpmc_oen   active-low bus strobes
//   gpmc_clk              bus clock, clk/2 while busy, held low when idle
module gpmc_initiator #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_CYC   = 1,
  parameter int DATA_CYC   = 1,
  parameter int TURN_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [15:0]           gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [15:0]           gpmc_ad_in,
  output logic                  gpmc_advn,
  output logic                  gpmc_csn1,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic                  gpmc_clk
);

  localparam int MAX_AD  = (ADDR_CYC > DATA_CYC) ? ADDR_CYC : DATA_CYC;
  localparam int MAX_CYC = (MAX_AD > TURN_CYC) ? MAX_AD : TURN_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;       // periods left in the current phase
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]           ad_out_q, ad_out_d;
  logic                  ad_oe_q, ad_oe_d;
  logic                  advn_q, advn_d;
  logic                  csn_q, csn_d;
  logic                  wein_q, wein_d;
  logic                  oen_q, oen_d;
  logic                  gclk_q, gclk_d;

  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    ad_out_d    = ad_out_q;
    ad_oe_d     = ad_oe_q;
    advn_d      = advn_q;
    csn_d       = csn_q;
    wein_d      = wein_q;
    oen_d       = oen_q;
    gclk_d      = gclk_q;

    case (state_q)
      IDLE: begin
        gclk_d = 1'b0;
        if (cmd_valid && ready_q) begin
          // The address phase values are loaded here so they appear on the
          // very next cycle; ad_out_q itself holds the captured address.
          state_d  = ADDR;
          cnt_d    = CNT_W'(ADDR_CYC);
          write_d  = cmd_write;
          wdata_d  = cmd_wdata;
          ready_d  = 1'b0;
          csn_d    = 1'b0;
          advn_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = 16'(cmd_addr);
          wein_d   = !cmd_write;
          oen_d    = 1'b1;
        end
      end
      ADDR, DATA, TURN: begin
        gclk_d = !gclk_q;
        // Phase changes happen only at the end of the gpmc_clk-high cycle,
        // i.e. on a period boundary.
        if (gclk_q) begin
          if (cnt_q == CNT_W'(1)) begin
            case (state_q)
              ADDR: begin
                state_d = DATA;
                cnt_d   = CNT_W'(DATA_CYC);
                advn_d  = 1'b1;
                // ad_oe drops in the same edge that oen asserts, so the two
                // drivers never overlap on a read.
                if (write_q) begin
                  ad_oe_d  = 1'b1;
                  ad_out_d = 16'(wdata_q);
                  wein_d   = 1'b0;
                  oen_d    = 1'b1;
                end else begin
                  ad_oe_d  = 1'b0;
                  ad_out_d = 16'h0000;
                  wein_d   = 1'b1;
                  oen_d    = 1'b0;
                end
              end
              DATA: begin
                state_d     = TURN;
                cnt_d       = CNT_W'(TURN_CYC);
                csn_d       = 1'b1;
                advn_d      = 1'b1;
                wein_d      = 1'b1;
                oen_d       = 1'b1;
                ad_oe_d     = 1'b0;
                ad_out_d    = 16'h0000;
                rsp_valid_d = 1'b1;
                if (!write_q) rdata_d = DATA_WIDTH'(gpmc_ad_in);
              end
              default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ad_out_q    <= 16'h0000;
      ad_oe_q     <= 1'b0;
      advn_q      <= 1'b1;
      csn_q       <= 1'b1;
      wein_q      <= 1'b1;
      oen_q       <= 1'b1;
      gclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      advn_q      <= advn_d;
      csn_q       <= csn_d;
      wein_q      <= wein_d;
      oen_q       <= oen_d;
      gclk_q      <= gclk_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign gpmc_ad_out = ad_out_q;
  assign gpmc_ad_oe  = ad_oe_q;
  assign gpmc_advn   = advn_q;
  assign gpmc_csn1   = csn_q;
  assign gpmc_wein   = wein_q;
  assign gpmc_oen    = oen_q;
  assign gpmc_clk    = gclk_q;

endmodule

// File: tb/tb_gpmc_initiator.sv
// Bench for gpmc_initiator. Two instances: d1 with default timing, attached
// to a small behavioural GPMC target memory, and d2 with ADDR_CYC=2,
// DATA_CYC=3, TURN_CYC=1 whose read data encodes the cycle it was driven in.
// A per-instance reference model derives the expected bus from the offset of
// the current cycle since acceptance.
module tb_gpmc_initiator;

  localparam int A1 = 1, D1 = 1, T1 = 1;
  localparam int A2 = 2, D2 = 3, T2 = 1;

  typedef struct packed {
    logic        gclk;
    logic        csn;
    logic        advn;
    logic        wein;
    logic        oen;
    logic        oe;
    logic [15:0] ad;
  } bus_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 1 signals
  logic        c1_valid = 1'b0, c1_write = 1'b0;
  logic [4:0]  c1_addr = '0;
  logic [15:0] c1_wdata = '0;
  logic        o1_ready, o1_rv, o1_oe, o1_advn, o1_csn, o1_wein, o1_oen, o1_gclk;
  logic [15:0] o1_rd, o1_ad, ad_in1;
  // instance 2 signals
  logic        c2_valid = 1'b0, c2_write = 1'b0;
  logic [4:0]  c2_addr = '0;
  logic [15:0] c2_wdata = '0;
  logic        o2_ready, o2_rv, o2_oe, o2_advn, o2_csn, o2_wein, o2_oen, o2_gclk;
  logic [15:0] o2_rd, o2_ad, ad_in2;

  gpmc_initiator #(.ADDR_CYC(A1), .DATA_CYC(D1), .TURN_CYC(T1)) d1 (
    .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(o1_ready),
    .cmd_write(c1_write), .cmd_addr(c1_addr), .cmd_wdata(c1_wdata),
    .rsp_valid(o1_rv), .rsp_rdata(o1_rd), .gpmc_ad_out(o1_ad), .gpmc_ad_oe(o1_oe),
    .gpmc_ad_in(ad_in1), .gpmc_advn(o1_advn), .gpmc_csn1(o1_csn),
    .gpmc_wein(o1_wein), .gpmc_oen(o1_oen), .gpmc_clk(o1_gclk));

  gpmc_initiator #(.ADDR_CYC(A2), .DATA_CYC(D2), .TURN_CYC(T2)) d2 (
    .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(o2_ready),
    .cmd_write(c2_write), .cmd_addr(c2_addr), .cmd_wdata(c2_wdata),
    .rsp_valid(o2_rv), .rsp_rdata(o2_rd), .gpmc_ad_out(o2_ad), .gpmc_ad_oe(o2_oe),
    .gpmc_ad_in(ad_in2), .gpmc_advn(o2_advn), .gpmc_csn1(o2_csn),
    .gpmc_wein(o2_wein), .gpmc_oen(o2_oen), .gpmc_clk(o2_gclk));

  function automatic logic [15:0] init_val(input int i);
    return (i == 3) ? 16'h1234 : 16'(16'h0100 + i);
  endfunction

  // Expected bus for the k-th cycle after acceptance (1-based); idle values
  // when not busy.
  function automatic bus_t exp_bus(input bit busy, input int k, input int a, input int d,
                                   input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
    bus_t b;
    b = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    if (busy) begin
      b.gclk = ((k - 1) % 2) == 1;
      if (k <= 2 * a) begin
        b.csn = 1'b0; b.advn = 1'b0; b.oe = 1'b1; b.ad = addr; b.wein = !wr;
      end else if (k <= 2 * (a + d)) begin
        b.csn = 1'b0;
        if (wr) begin b.oe = 1'b1; b.ad = wdata; b.wein = 1'b0; end
        else b.oen = 1'b0;
      end
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- GPMC target for d1 ----------------
  logic [15:0] tgt_mem [32];
  logic [4:0]  tgt_addr;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) tgt_mem[i] <= init_val(i);
      tgt_addr <= '0;
    end else if (!o1_csn && o1_gclk) begin
      if (!o1_advn) tgt_addr <= o1_ad[4:0];
      else if (!o1_wein && o1_oe) tgt_mem[tgt_addr] <= o1_ad;
    end
  end
  assign ad_in1 = !o1_oen ? tgt_mem[tgt_addr] : 16'hF0F0;

  // ---------------- reference model, d1 ----------------
  bit          m1_busy = 1'b0, m1_wr = 1'b0;
  int          m1_k = 0;
  logic [4:0]  m1_addr = '0;
  logic [15:0] m1_wdata = '0, m1_rdata = '0;
  logic [15:0] exp_mem [32];
  always @(posedge clk) begin
    if (reset) begin
      m1_busy  <= 1'b0;
      m1_rdata <= '0;
      for (int i = 0; i < 32; i++) exp_mem[i] <= init_val(i);
    end else if (m1_busy) begin
      if (m1_k == 2 * (A1 + D1)) begin
        if (m1_wr) exp_mem[m1_addr] <= m1_wdata;
        else m1_rdata <= exp_mem[m1_addr];
      end
      if (m1_k == 2 * (A1 + D1 + T1)) m1_busy <= 1'b0;
      else m1_k <= m1_k + 1;
    end else if (c1_valid) begin
      m1_busy <= 1'b1; m1_k <= 1;
      m1_wr <= c1_write; m1_addr <= c1_addr; m1_wdata <= c1_wdata;
    end
  end

  // ---------------- reference model, d2 ----------------
  bit          m2_busy = 1'b0, m2_wr = 1'b0;
  int          m2_k = 0;
  logic [4:0]  m2_addr = '0;
  logic [15:0] m2_wdata = '0, m2_rdata = '0;
  always @(posedge clk) begin
    if (reset) begin
      m2_busy  <= 1'b0;
      m2_rdata <= '0;
    end else if (m2_busy) begin
      if (m2_k == 2 * (A2 + D2) && !m2_wr) m2_rdata <= 16'h5A00 | 16'(m2_k);
      if (m2_k == 2 * (A2 + D2 + T2)) m2_busy <= 1'b0;
      else m2_k <= m2_k + 1;
    end else if (c2_valid) begin
      m2_busy <= 1'b1; m2_k <= 1;
      m2_wr <= c2_write; m2_addr <= c2_addr; m2_wdata <= c2_wdata;
    end
  end
  // Read data tags the cycle it is presented in, exposing when it is sampled.
  assign ad_in2 = !o2_oen ? (16'h5A00 | 16'(m2_k)) : 16'h0000;

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string tag, input bus_t a, input bus_t e, input bit busy,
                     input logic rdy, input logic rv, input logic erv,
                     input logic [15:0] rd, input logic [15:0] erd);
    check({tag, " gpmc_clk"}, 16'(a.gclk), 16'(e.gclk));
    check({tag, " csn1"}, 16'(a.csn), 16'(e.csn));
    check({tag, " advn"}, 16'(a.advn), 16'(e.advn));
    check({tag, " wein"}, 16'(a.wein), 16'(e.wein));
    check({tag, " oen"}, 16'(a.oen), 16'(e.oen));
    check({tag, " ad_oe"}, 16'(a.oe), 16'(e.oe));
    if (e.oe || !busy) check({tag, " ad_out"}, a.ad, e.ad);
    check({tag, " contention"}, 16'(a.oe && !a.oen), 16'd0);
    check({tag, " cmd_ready"}, 16'(rdy), 16'(!busy));
    check({tag, " rsp_valid"}, 16'(rv), 16'(erv));
    check({tag, " rsp_rdata"}, rd, erd);
  endtask

  int rsp1_cnt = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("d1", {o1_gclk, o1_csn, o1_advn, o1_wein, o1_oen, o1_oe, o1_ad},
          exp_bus(m1_busy, m1_k, A1, D1, m1_wr, 16'(m1_addr), m1_wdata), m1_busy,
          o1_ready, o1_rv, m1_busy && (m1_k == 2 * (A1 + D1) + 1), o1_rd, m1_rdata);
      cmp("d2", {o2_gclk, o2_csn, o2_advn, o2_wein, o2_oen, o2_oe, o2_ad},
          exp_bus(m2_busy, m2_k, A2, D2, m2_wr, 16'(m2_addr), m2_wdata), m2_busy,
          o2_ready, o2_rv, m2_busy && (m2_k == 2 * (A2 + D2) + 1), o2_rd, m2_rdata);
      if (o1_rv) rsp1_cnt <= rsp1_cnt + 1;
    end
  end

  // Present a command at a negedge, wait (bounded) until it is accepted, and
  // return at the negedge of the first cycle after acceptance.
  task automatic issue(input bit which, input bit hold, input bit wr, input logic [4:0] a,
                       input logic [15:0] d, output int acc);
    int n;
    n = 0;
    if (!which) begin c1_valid = 1'b1; c1_write = wr; c1_addr = a; c1_wdata = d; end
    else        begin c2_valid = 1'b1; c2_write = wr; c2_addr = a; c2_wdata = d; end
    while (!(which ? o2_ready : o1_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 16'(which ? o2_ready : o1_ready), 16'd1);
    acc = cyc;
    @(negedge clk);
    if (!hold) begin c1_valid = 1'b0; c2_valid = 1'b0; end
  endtask

  initial begin
    int acc1, acc2, r0, nadv, noen, rvk;
    logic [6:0] w_csn, w_advn, w_rv, w_rdy, w_gclk;
    w_csn  = 7'b1110000;   // bit k-1 = value in cycle k after acceptance
    w_advn = 7'b1111100;
    w_rv   = 7'b0010000;
    w_rdy  = 7'b1000000;
    w_gclk = 7'b0101010;

    @(negedge clk);
    chk_en = 1'b1;
    check("reset cmd_ready", 16'(o1_ready), 16'd1);
    check("reset csn1", 16'(o1_csn), 16'd1);
    check("reset rsp_rdata", o1_rd, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // write 0x0A <- 0xBEEF
    issue(1'b0, 1'b0, 1'b1, 5'h0A, 16'hBEEF, acc1);
    for (int k = 1; k <= 7; k++) begin
      check("wr csn1", 16'(o1_csn), 16'(w_csn[k-1]));
      check("wr advn", 16'(o1_advn), 16'(w_advn[k-1]));
      check("wr rsp_valid", 16'(o1_rv), 16'(w_rv[k-1]));
      check("wr cmd_ready", 16'(o1_ready), 16'(w_rdy[k-1]));
      check("wr gpmc_clk", 16'(o1_gclk), 16'(w_gclk[k-1]));
      if (k == 1) check("wr addr phase", o1_ad, 16'h000A);
      if (k == 1) check("wr wein in addr", 16'(o1_wein), 16'd0);
      if (k == 3) check("wr data phase", o1_ad, 16'hBEEF);
      if (k == 5) check("wr turn oe", 16'(o1_oe), 16'd0);
      if (k < 7) @(negedge clk);
    end

    // read 0x03, target returns 0x1234
    issue(1'b0, 1'b0, 1'b0, 5'h03, 16'h0000, acc1);
    repeat (2) @(negedge clk);
    check("rd oen", 16'(o1_oen), 16'd0);
    check("rd ad_oe", 16'(o1_oe), 16'd0);
    repeat (2) @(negedge clk);
    check("rd rsp_valid", 16'(o1_rv), 16'd1);
    check("rd rsp_rdata", o1_rd, 16'h1234);
    repeat (2) @(negedge clk);

    // back-to-back: write then read with cmd_valid held
    r0 = rsp1_cnt;
    issue(1'b0, 1'b1, 1'b1, 5'h01, 16'h5555, acc1);
    issue(1'b0, 1'b0, 1'b0, 5'h03, 16'h0000, acc2);
    check("b2b spacing", 16'(acc2 - acc1), 16'd7);
    check("b2b rdata after write", o1_rd, 16'h1234);
    repeat (8) @(negedge clk);
    check("b2b rsp count", 16'(rsp1_cnt - r0), 16'd2);
    check("b2b rdata", o1_rd, 16'h1234);

    // reset in the first data cycle of a write
    issue(1'b0, 1'b0, 1'b1, 5'h02, 16'h7777, acc1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst csn1", 16'(o1_csn), 16'd1);
    check("rst wein", 16'(o1_wein), 16'd1);
    check("rst ad_oe", 16'(o1_oe), 16'd0);
    check("rst gpmc_clk", 16'(o1_gclk), 16'd0);
    check("rst cmd_ready", 16'(o1_ready), 16'd1);
    check("rst rsp_rdata", o1_rd, 16'h0000);
    reset = 1'b0;
    r0 = rsp1_cnt;
    repeat (6) @(negedge clk);
    check("rst no rsp", 16'(rsp1_cnt - r0), 16'd0);

    // loopback through the target: write 0x000F to 0, read it back
    issue(1'b0, 1'b0, 1'b1, 5'h00, 16'h000F, acc1);
    repeat (6) @(negedge clk);
    check("loop led", 16'(tgt_mem[0][3:0]), 16'h000F);
    issue(1'b0, 1'b0, 1'b0, 5'h00, 16'h0000, acc1);
    repeat (4) @(negedge clk);
    check("loop readback", o1_rd, 16'h000F);
    repeat (2) @(negedge clk);

    // d2 (A=2, D=3, T=1): read, then write
    nadv = 0; noen = 0; rvk = 0;
    issue(1'b1, 1'b0, 1'b0, 5'h07, 16'h0000, acc1);
    for (int k = 1; k <= 12; k++) begin
      if (!o2_advn) nadv++;
      if (!o2_oen) noen++;
      if (o2_rv) rvk = k;
      if (k == 11) check("d2 rdata sampled in cycle 10", o2_rd, 16'h5A0A);
      if (k < 12) @(negedge clk);
    end
    check("d2 advn low cycles", 16'(nadv), 16'd4);
    check("d2 data cycles", 16'(noen), 16'd6);
    check("d2 rsp_valid cycle", 16'(rvk), 16'd11);
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b1, 5'h15, 16'hC3C3, acc1);
    repeat (4) @(negedge clk);
    check("d2 wr data", o2_ad, 16'hC3C3);
    repeat (10) @(negedge clk);
    check("d2 idle ready", 16'(o2_ready), 16'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/gpmc_initiator.md
Name: gpmc_initiator

Overview:
- Synchronous multiplexed GPMC bus master. It is the initiator-side counterpart of gpmc_to_wishbone: it drives gpmc_clk, gpmc_advn, gpmc_csn1, gpmc_wein, gpmc_oen and the gpmc_ad bus from a simple valid/ready command port.
- Purpose: FPGA-side loopback and self-test of the GPMC bridge, plus the bench driver for Wishbone peripheral simulation without a BeagleBone.
- Single outstanding transaction. One done/response pulse per command.

Parameters:
- ADDR_WIDTH, 5, number of address bits presented on gpmc_ad[ADDR_WIDTH-1:0]. Legal range 1..16.
- DATA_WIDTH, 16, data width of the GPMC bus. Fixed at 16.
- ADDR_CYC, 1, GPMC clock periods in the address phase. Must be ≥1.
- DATA_CYC, 1, GPMC clock periods in the data phase. Must be ≥1.
- TURN_CYC, 1, GPMC clock periods with chip select deasserted after each access. Must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  word address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle done pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads.
- gpmc_ad_out  out  16  address/data driven onto the bus.
- gpmc_ad_oe  out  1  tristate enable for gpmc_ad_out.
- gpmc_ad_in  in  16  bus readback.
- gpmc_advn  out  1  address valid, active low.
- gpmc_csn1  out  1  chip select, active low.
- gpmc_wein  out  1  write enable, active low.
- gpmc_oen  out  1  output enable, active low.
- gpmc_clk  out  1  GPMC clock, clk/2.

Behaviour:
- Reset values and IDLE values: gpmc_clk=0, gpmc_csn1=1, gpmc_advn=1, gpmc_wein=1, gpmc_oen=1, gpmc_ad_oe=0, gpmc_ad_out=0, rsp_valid=0, rsp_rdata=0, cmd_ready=1.
- GPMC period = 2 clk cycles:
  - gpmc_clk=0 in the first cycle of a period, 1 in the second.
  - gpmc_clk is held 0 in IDLE.
  - All bus outputs change only at period boundaries, i.e. on the gpmc_clk falling edge. The target samples on the rising edge.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_addr, cmd_wdata and cmd_write are registered on acceptance; inputs are don't-care afterwards.
  - The ADDR phase starts the next cycle.
- States:
  - IDLE
  - ADDR (ADDR_CYC periods): csn1=0, advn=0, ad_oe=1, ad_out = zero-extended cmd_addr, wein=!cmd_write, oen=1.
  - DATA (DATA_CYC periods): csn1=0, advn=1.
    - Write: ad_oe=1, ad_out=wdata, wein=0.
    - Read: ad_oe=0, oen=0, wein=1.
  - TURN (TURN_CYC periods): csn1=1, advn=1, wein=1, oen=1, ad_oe=0. Then return to IDLE.
- Read sampling: rsp_rdata is loaded from gpmc_ad_in on the clk edge ending the last DATA period, i.e. the gpmc_clk-high cycle of that period.
- Response:
  - rsp_valid pulses for exactly 1 cycle, in the first cycle of TURN, for both reads and writes.
  - rsp_rdata holds its value until the next read. Writes do not change it.
- Latency:
  - Busy time = 2·(ADDR_CYC+DATA_CYC+TURN_CYC) cycles after acceptance.
  - Back-to-back throughput is one command per 2·(A+D+T)+1 cycles, since cmd_ready is asserted for the IDLE cycle.
- Period counter width: clog2(max(ADDR_CYC, DATA_CYC, TURN_CYC)+1). Wrap is not permitted; the counter reloads on each state entry.
- Reset mid-operation:
  - Next cycle, all outputs are at reset values and the state is IDLE.
  - The in-flight command is dropped with no rsp_valid.
  - rsp_rdata is cleared to 0.
- cmd_valid asserted while busy is ignored until IDLE. It must be held by the source.
- gpmc_ad_oe is never 1 while gpmc_oen=0. There is no bus contention in any state.

Test Plan:
- Write, defaults: cmd addr=5'h0A, wdata=16'hBEEF, write=1, accepted cycle 0.
  - Cycles 1–2: csn1=0, advn=0, ad_out=16'h000A, wein=0, oe=1.
  - Cycles 3–4: advn=1, ad_out=16'hBEEF.
  - Cycles 5–6: csn1=1, oe=0.
  - rsp_valid in cycle 5 only; cmd_ready=1 in cycle 7.
- Read, defaults: addr=5'h03, bench drives gpmc_ad_in=16'h1234 while oen=0.
  - Cycles 3–4: oen=0, ad_oe=0.
  - rsp_valid in cycle 5 with rsp_rdata=16'h1234.
  - gpmc_clk toggles 0,1 per period.
- Back-to-back: cmd_valid held high with a write then a read.
  - Second acceptance occurs exactly 7 cycles after the first.
  - Exactly two rsp_valid pulses.
  - rsp_rdata unchanged by the write.
- Reset mid-DATA (assert reset at cycle 3 of a write):
  - Cycle 4: csn1=1, wein=1, ad_oe=0, gpmc_clk=0, cmd_ready=1.
  - No rsp_valid.
- Parameters ADDR_CYC=2, DATA_CYC=3, TURN_CYC=1:
  - advn low for 4 cycles, data phase 6 cycles, rsp_valid at cycle 11 after acceptance.
  - Read data sampled at the end of cycle 10.
- Full DUT-to-DUT loopback, gpmc_initiator into gpmc_to_wishbone into leds_wb:
  - Write 16'h000F to addr 0: led=4'hF.
  - Read addr 0 returns 16'h000F.
